// File: rtl/stepper_pkg.sv
// Shared stepper-interface types: FSM states, default widths, saturating increment.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stepper_pkg;

  // Measurement FSM states, shared with the driver-side blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STALL = 2'd3
  } step_state_t;

  localparam int STEP_SIZE_DEF   = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Increment that sticks at max_v instead of wrapping.
  // Callers narrower than 32 bits zero-extend into it and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an async input and flags its rising/falling edges.
// Latency: STAGES clocks to step_s; rise/fall are combinational from step_s and its delayed copy.
// Backpressure: none; edges are single-cycle flags and must be consumed when asserted.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic step_s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign step_s = sync_q[STAGES-1];
  assign rise   = step_s & ~dly_q;
  assign fall   = ~step_s & dly_q;

endmodule

// File: rtl/step_pulse_meter.sv
// Measures period and high time of STEP pulses, counts steps, flags stalls.
// Latency: meas_valid appears SYNC_STAGES+1 cycles after step_in is first sampled high.
// Backpressure: none; meas_valid is a one-cycle strobe, results hold until the next one.
module step_pulse_meter
  import stepper_pkg::*;
#(
  parameter int SIZE        = STEP_SIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              step_in,
  input  logic [SIZE-1:0]   timeout_lim,
  input  logic              count_clr,
  output logic [SIZE-1:0]   period,
  output logic [SIZE-1:0]   high_width,
  output logic              meas_valid,
  output logic [2*SIZE-1:0] step_count,
  output logic              stalled
);

  localparam logic [SIZE-1:0] CNT_MAX = '1;
  localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);

  logic            step_s;
  logic            rise;
  logic            fall;
  step_state_t     state;
  logic [SIZE-1:0] per_cnt;
  logic [SIZE-1:0] hi_cnt;
  logic [SIZE-1:0] hw_hold;
  logic            stall_hit;

  // SIZE is limited to 32 by the shared 32-bit helper.
  function automatic logic [SIZE-1:0] inc_sat(input logic [SIZE-1:0] v);
    return SIZE'(sat_inc(32'(v), 32'(CNT_MAX)));
  endfunction

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (step_in),
    .step_s (step_s),
    .rise   (rise),
    .fall   (fall)
  );

  // A zero limit disables stall detection; limit is re-evaluated every cycle.
  assign stall_hit = (timeout_lim != '0) && (per_cnt >= timeout_lim);

  // Measurement FSM with period/high-time counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      hw_hold    <= '0;
      period     <= '0;
      high_width <= '0;
      meas_valid <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
        hw_hold <= '0;
        stalled <= 1'b0;
      end else begin
        // High time runs in every active state, including through a stall,
        // so a pulse straddling a stall still reports its full width.
        if (state != IDLE) begin
          if (rise) begin
            hi_cnt <= CNT_ONE;
          end else if (step_s) begin
            hi_cnt <= inc_sat(hi_cnt);
          end
          if (fall) begin
            hw_hold <= hi_cnt;
          end
        end
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            // First edge only provides the reference; nothing to report yet.
            if (rise) begin
              state   <= MEAS;
              per_cnt <= CNT_ONE;
            end
          end
          MEAS: begin
            if (rise) begin
              period     <= per_cnt;
              high_width <= hw_hold;
              meas_valid <= 1'b1;
              per_cnt    <= CNT_ONE;
            end else begin
              per_cnt <= inc_sat(per_cnt);
              if (stall_hit) begin
                state   <= STALL;
                stalled <= 1'b1;
              end
            end
          end
          STALL: begin
            // The gap that caused the stall is not a valid period; restart from here.
            if (rise) begin
              state   <= MEAS;
              stalled <= 1'b0;
              per_cnt <= CNT_ONE;
            end else begin
              per_cnt <= inc_sat(per_cnt);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Step counter: counts every enabled rise regardless of FSM state; clear wins over
  // the old value but a coincident rise still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_count <= '0;
    end else if (count_clr) begin
      step_count <= (enable && rise) ? (2*SIZE)'(1) : '0;
    end else if (enable && rise) begin
      step_count <= step_count + (2*SIZE)'(1);
    end
  end

endmodule

// File: tb/tb_step_pulse_meter.sv
// Testbench for step_pulse_meter: table-driven pulse trains, hand-written corner
// sequences and a randomized run against an event-time reference model.
module tb_step_pulse_meter;

  localparam int NS  = 2;
  localparam int SZ  = 8;
  localparam int MAX = 255;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          step_in;
  logic [SZ-1:0] timeout_lim;
  logic          count_clr;

  logic [SZ-1:0]   period;
  logic [SZ-1:0]   high_width;
  logic            meas_valid;
  logic [2*SZ-1:0] step_count;
  logic            stalled;

  logic [3:0] period4;
  logic [3:0] high_width4;
  logic       meas_valid4;
  logic [7:0] step_count4;
  logic       stalled4;

  step_pulse_meter #(.SIZE(SZ), .SYNC_STAGES(NS)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .step_in     (step_in),
    .timeout_lim (timeout_lim),
    .count_clr   (count_clr),
    .period      (period),
    .high_width  (high_width),
    .meas_valid  (meas_valid),
    .step_count  (step_count),
    .stalled     (stalled)
  );

  step_pulse_meter #(.SIZE(4), .SYNC_STAGES(NS)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .step_in     (step_in),
    .timeout_lim (4'd0),
    .count_clr   (count_clr),
    .period      (period4),
    .high_width  (high_width4),
    .meas_valid  (meas_valid4),
    .step_count  (step_count4),
    .stalled     (stalled4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tot = 0;
  int n_bad = 0;
  int n_strobe = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    step_in = 1'b0;
    count_clr = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  // ---------------- reference model (event times, plain arithmetic) ----------------
  logic [NS+1:0] sh = '0;   // sh[k] = step_in sampled k edges ago
  logic c_rst, c_en, c_clr;
  int   c_lim;
  int   tcyc = 0;
  bit   m_have, m_stalled, m_mv;
  int   m_last, m_rise_t, m_hw, m_hw_out, m_period, m_cnt;

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      sh    = {sh[NS:0], step_in};
      c_rst = rst;
      c_en  = enable;
      c_lim = int'(timeout_lim);
      c_clr = count_clr;
    end
  end

  task automatic model_step();
    logic r, f;
    r = sh[NS] & ~sh[NS+1];
    f = ~sh[NS] & sh[NS+1];
    m_mv = 1'b0;
    if (c_rst) begin
      sh = '0;
      m_have = 0; m_stalled = 0; m_period = 0; m_hw_out = 0; m_hw = 0;
      m_cnt = 0; m_last = 0; m_rise_t = 0;
    end else begin
      if (c_clr) m_cnt = (r && c_en) ? 1 : 0;
      else if (r && c_en) m_cnt++;
      if (!c_en) begin
        m_have = 0; m_stalled = 0; m_hw = 0;
      end else if (r) begin
        if (m_have && !m_stalled) begin
          m_mv = 1'b1;
          m_period = sat(tcyc - m_last);
          m_hw_out = m_hw;
        end
        m_have = 1; m_last = tcyc; m_rise_t = tcyc; m_stalled = 0;
      end else begin
        if (f) m_hw = sat(tcyc - m_rise_t);
        if (!m_stalled)
          m_stalled = m_have && (c_lim != 0) && (sat(tcyc - m_last) >= c_lim);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      tcyc++;
      model_step();
      if (meas_valid) n_strobe++;
      if (chk_on) begin
        chk("rnd_meas_valid", int'(meas_valid), int'(m_mv));
        chk("rnd_period", int'(period), m_period);
        chk("rnd_high_width", int'(high_width), m_hw_out);
        chk("rnd_stalled", int'(stalled), int'(m_stalled));
        chk("rnd_step_count", int'(step_count), m_cnt % 65536);
        chk("rnd_step_count4", int'(step_count4), m_cnt % 256);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int per; int hi; int npulse; int lim;
    int exp_period; int exp_hw; int exp_strobes; int exp_count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0, lat, first;
    vecs[0] = '{20, 5, 4, 0, 20, 5, 3, 4};
    vecs[1] = '{7, 1, 5, 0, 7, 1, 4, 5};
    vecs[2] = '{300, 10, 3, 0, 255, 10, 2, 3};
    vecs[3] = '{30, 29, 3, 0, 30, 29, 2, 3};
    vecs[4] = '{12, 4, 3, 100, 12, 4, 2, 3};
    vecs[5] = '{400, 300, 2, 0, 255, 255, 1, 2};

    rst = 1'b1; enable = 1'b0; step_in = 1'b0; count_clr = 1'b0; timeout_lim = '0;

    // 1: reset / idle with step_in toggling
    s0 = n_strobe;
    for (int i = 0; i < 3; i++) begin step_in = ~step_in; tick(1); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin step_in = ~step_in; tick(1); end
    step_in = 1'b0; tick(3);
    chk("idle_period", int'(period), 0);
    chk("idle_high_width", int'(high_width), 0);
    chk("idle_stalled", int'(stalled), 0);
    chk("idle_step_count", int'(step_count), 0);
    chk("idle_strobes", n_strobe - s0, 0);

    // table-driven pulse trains
    for (int v = 0; v < 6; v++) begin
      do_reset();
      enable = 1'b1;
      timeout_lim = SZ'(vecs[v].lim);
      tick(4);
      s0 = n_strobe;
      for (int p = 0; p < vecs[v].npulse; p++) pulse(vecs[v].hi, vecs[v].per - vecs[v].hi);
      tick(6);
      chk($sformatf("vec%0d_strobes", v), n_strobe - s0, vecs[v].exp_strobes);
      chk($sformatf("vec%0d_period", v), int'(period), vecs[v].exp_period);
      chk($sformatf("vec%0d_high_width", v), int'(high_width), vecs[v].exp_hw);
      chk($sformatf("vec%0d_step_count", v), int'(step_count), vecs[v].exp_count);
      chk($sformatf("vec%0d_stalled", v), int'(stalled), 0);
    end

    // 2: latency of first strobe after the second rising sample
    do_reset();
    enable = 1'b1; timeout_lim = '0;
    tick(4);
    pulse(5, 15);
    step_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 5) step_in = 1'b0;
      if (meas_valid && lat == 0) lat = k;
    end
    chk("latency", lat, NS + 1);

    // 3: stall timing, recovery without strobe, then a valid period
    do_reset();
    enable = 1'b1; timeout_lim = 8'd50;
    tick(4);
    pulse(5, 15);
    pulse(5, 15);
    step_in = 1'b1;
    first = 0;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (k == 5) step_in = 1'b0;
      if (stalled && first == 0) first = k;
    end
    chk("stall_time", first, NS + 1 + 50);
    s0 = n_strobe;
    pulse(5, 15);
    chk("stall_cleared", int'(stalled), 0);
    chk("stall_no_strobe", n_strobe - s0, 0);
    pulse(5, 15);
    chk("post_stall_strobes", n_strobe - s0, 1);
    chk("post_stall_period", int'(period), 20);
    chk("post_stall_high_width", int'(high_width), 5);

    // 5: counter wrap and clear corner cases
    do_reset();
    enable = 1'b1; timeout_lim = '0;
    tick(4);
    for (int p = 0; p < 255; p++) pulse(2, 2);
    tick(4);
    chk("preload_count4", int'(step_count4), 255);
    chk("preload_count", int'(step_count), 255);
    pulse(2, 2);
    tick(3);
    chk("wrap_count4", int'(step_count4), 0);
    chk("wrap_count", int'(step_count), 256);
    step_in = 1'b1;
    tick(2);            // rise is now in the current cycle
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    chk("clr_rise_count", int'(step_count), 1);
    chk("clr_rise_count4", int'(step_count4), 1);
    step_in = 1'b0;
    tick(5);
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    chk("clr_only_count", int'(step_count), 0);
    pulse(2, 4);
    enable = 1'b0;
    count_clr = 1'b1; tick(1); count_clr = 1'b0;
    chk("clr_disabled_count", int'(step_count), 0);

    // 6: disable mid-pulse, re-arm, then reset mid-train
    do_reset();
    enable = 1'b1; timeout_lim = '0;
    tick(4);
    for (int p = 0; p < 3; p++) pulse(4, 10);
    chk("pre_disable_period", int'(period), 14);
    step_in = 1'b1;
    tick(2);
    s0 = n_strobe;
    enable = 1'b0;
    tick(3);
    step_in = 1'b0;
    tick(5);
    chk("disable_no_strobe", n_strobe - s0, 0);
    chk("disable_stalled", int'(stalled), 0);
    enable = 1'b1;
    tick(3);
    pulse(6, 14);
    chk("rearm_no_strobe", n_strobe - s0, 0);
    pulse(6, 14);
    chk("rearm_strobes", n_strobe - s0, 1);
    chk("rearm_period", int'(period), 20);
    chk("rearm_high_width", int'(high_width), 6);
    pulse(6, 14);
    step_in = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_period", int'(period), 0);
    chk("rst_mid_high_width", int'(high_width), 0);
    chk("rst_mid_meas_valid", int'(meas_valid), 0);
    chk("rst_mid_step_count", int'(step_count), 0);
    chk("rst_mid_stalled", int'(stalled), 0);
    rst = 1'b0;
    step_in = 1'b0;

    // randomized run against the reference model
    do_reset();
    enable = 1'b1;
    timeout_lim = SZ'($urandom_range(0, 60));
    tick(6);
    chk_on = 1;
    for (int p = 0; p < 60; p++) begin
      int hi, lo;
      if ($urandom_range(0, 3) == 0) timeout_lim = SZ'($urandom_range(0, 60));
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 40);
      if ($urandom_range(0, 7) == 0) count_clr = 1'b1;
      step_in = 1'b1;
      tick(1);
      count_clr = 1'b0;
      if (hi > 1) tick(hi - 1);
      step_in = 1'b0;
      tick(lo);
    end
    tick(70);
    chk_on = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
